boton_pulsacion_larga: RTL and testbench

- Button-conditioning front end; one instance per physical button (test, food, medicine, reset).
- Sits directly upstream of the modes block.
- Synchronises and debounces the raw pad, then classifies each press into one of:
  - press-confirmed pulse;
  - short-press pulse;
  - long-hold pulse, which the modes block consumes as its 5-second hold event;
  - release pulse.
- Also provides a clean debounced level and a held-past-threshold level for LED and test-mode logic.

---
 rtl/boton_pulsacion_larga.sv | 149 ++++++++++++++
 tb/tb_boton_pulsacion_larga.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/boton_pulsacion_larga.sv
// Button front end: two-flop synchroniser, debouncer and press classifier
// (press / short / long-hold / release pulses plus debounced and held levels).
module boton_pulsacion_larga #(
    parameter int unsigned DEB_CYCLES  = 1_000_000,
    parameter int unsigned HOLD_CYCLES = 250_000_000,
    parameter bit          ACTIVE_LOW  = 1'b1
) (
    input  logic clk,
    input  logic reset,
    input  logic boton_raw,
    output logic btn_level,
    output logic pulse_press,
    output logic pulse_short,
    output logic pulse_hold,
    output logic pulse_release,
    output logic hold_active
);

    localparam int unsigned DW = $clog2(DEB_CYCLES);
    localparam int unsigned HW = $clog2(HOLD_CYCLES);
    localparam logic [DW-1:0] DEB_LAST  = DW'(DEB_CYCLES - 1);
    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);
    localparam logic IDLE_LVL = ACTIVE_LOW;

    typedef enum logic [2:0] {
        IDLE,
        DEB_PRESS,
        PRESSED,
        HELD,
        DEB_RELEASE
    } state_t;

    state_t        state_q, state_d;
    logic [DW-1:0] deb_cnt, deb_d;
    logic [HW-1:0] hold_cnt, hold_d;
    logic          was_held, was_d;
    logic          lvl_d, hact_d;
    logic          press_d, short_d, holdp_d, rel_d;
    logic          sync1, sync2;
    logic          s;

    // Synchroniser idles at the pad's released level so reset never looks like a press
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1 <= IDLE_LVL;
            sync2 <= IDLE_LVL;
        end else begin
            sync1 <= boton_raw;
            sync2 <= sync1;
        end
    end

    assign s = ACTIVE_LOW ? ~sync2 : sync2;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= IDLE;
            deb_cnt       <= '0;
            hold_cnt      <= '0;
            was_held      <= 1'b0;
            btn_level     <= 1'b0;
            hold_active   <= 1'b0;
            pulse_press   <= 1'b0;
            pulse_short   <= 1'b0;
            pulse_hold    <= 1'b0;
            pulse_release <= 1'b0;
        end else begin
            state_q       <= state_d;
            deb_cnt       <= deb_d;
            hold_cnt      <= hold_d;
            was_held      <= was_d;
            btn_level     <= lvl_d;
            hold_active   <= hact_d;
            pulse_press   <= press_d;
            pulse_short   <= short_d;
            pulse_hold    <= holdp_d;
            pulse_release <= rel_d;
        end
    end

    always_comb begin
        state_d = state_q;
        deb_d   = deb_cnt;
        hold_d  = hold_cnt;
        was_d   = was_held;
        lvl_d   = btn_level;
        hact_d  = hold_active;
        press_d = 1'b0;
        short_d = 1'b0;
        holdp_d = 1'b0;
        rel_d   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (s) begin
                    state_d = DEB_PRESS;
                    deb_d   = '0;
                end
            end
            DEB_PRESS: begin
                if (!s) begin
                    state_d = IDLE;
                end else if (deb_cnt == DEB_LAST) begin
                    state_d = PRESSED;
                    press_d = 1'b1;
                    lvl_d   = 1'b1;
                    hold_d  = '0;
                    was_d   = 1'b0;
                end else begin
                    deb_d = deb_cnt + DW'(1);
                end
            end
            PRESSED: begin
                // Release is tested first so a glitch on the terminal cycle wins over the hold
                if (!s) begin
                    state_d = DEB_RELEASE;
                    deb_d   = '0;
                end else if (hold_cnt == HOLD_LAST) begin
                    state_d = HELD;
                    holdp_d = 1'b1;
                    hact_d  = 1'b1;
                    was_d   = 1'b1;
                end else begin
                    hold_d = hold_cnt + HW'(1);
                end
            end
            HELD: begin
                if (!s) begin
                    state_d = DEB_RELEASE;
                    deb_d   = '0;
                end
            end
            DEB_RELEASE: begin
                if (s) begin
                    state_d = was_held ? HELD : PRESSED;
                end else if (deb_cnt == DEB_LAST) begin
                    state_d = IDLE;
                    lvl_d   = 1'b0;
                    hact_d  = 1'b0;
                    rel_d   = 1'b1;
                    short_d = ~was_held;
                end else begin
                    deb_d = deb_cnt + DW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_boton_pulsacion_larga.sv
// Directed bench for boton_pulsacion_larga with DEB_CYCLES=4, HOLD_CYCLES=20;
// an active-low and an active-high instance share one logical press stream.
module tb_boton_pulsacion_larga;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic press = 1'b0;
    logic sel = 1'b0;
    logic raw_lo, raw_hi;

    logic lvl_lo, pp_lo, ps_lo, ph_lo, pr_lo, ha_lo;
    logic lvl_hi, pp_hi, ps_hi, ph_hi, pr_hi, ha_hi;
    logic [5:0] o;

    assign raw_lo = ~press;
    assign raw_hi = press;

    always #5 clk = ~clk;

    boton_pulsacion_larga #(.DEB_CYCLES(4), .HOLD_CYCLES(20), .ACTIVE_LOW(1'b1)) dut_lo (
        .clk(clk), .reset(reset), .boton_raw(raw_lo),
        .btn_level(lvl_lo), .pulse_press(pp_lo), .pulse_short(ps_lo),
        .pulse_hold(ph_lo), .pulse_release(pr_lo), .hold_active(ha_lo)
    );

    boton_pulsacion_larga #(.DEB_CYCLES(4), .HOLD_CYCLES(20), .ACTIVE_LOW(1'b0)) dut_hi (
        .clk(clk), .reset(reset), .boton_raw(raw_hi),
        .btn_level(lvl_hi), .pulse_press(pp_hi), .pulse_short(ps_hi),
        .pulse_hold(ph_hi), .pulse_release(pr_hi), .hold_active(ha_hi)
    );

    // {hold_active, pulse_release, pulse_hold, pulse_short, pulse_press, btn_level}
    assign o = sel ? {ha_hi, pr_hi, ph_hi, ps_hi, pp_hi, lvl_hi}
                   : {ha_lo, pr_lo, ph_lo, ps_lo, pp_lo, lvl_lo};

    int n_vec = 0;
    int n_bad = 0;

    int p_cnt, p_first, p_last, h_cnt, h_first, r_cnt, r_first, s_cnt, s_first;
    int both_cnt, hact_cnt, lvl_cnt;
    logic lvl_at [0:127];
    logic hact_at[0:127];

    task automatic check(input string tag, input int got, input int exp);
        n_vec++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic do_reset(input string tag);
        press = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check(tag, int'(o), 0);
        reset = 1'b0;
    endtask

    // Drives n edges; press spans edges ps..pe minus a glitch window, or a 2-cycle bounce
    task automatic run(input int n, input int ps, input int pe, input int gs, input int gl,
                       input int rst_at, input bit bounce);
        p_cnt = 0; p_first = 0; p_last = 0; h_cnt = 0; h_first = 0;
        r_cnt = 0; r_first = 0; s_cnt = 0; s_first = 0;
        both_cnt = 0; hact_cnt = 0; lvl_cnt = 0;
        for (int i = 0; i < 128; i++) begin
            lvl_at[i]  = 1'b0;
            hact_at[i] = 1'b0;
        end
        for (int k = 1; k <= n; k++) begin
            if (bounce)
                press = (k <= 16) && (((k - 1) / 2) % 2 == 0);
            else
                press = (k >= ps) && (k <= pe) && !((k >= gs) && (k < gs + gl));
            @(posedge clk);
            #1;
            lvl_at[k]  = o[0];
            hact_at[k] = o[5];
            if (o[0]) lvl_cnt++;
            if (o[5]) hact_cnt++;
            if (o[1]) begin p_cnt++; if (p_first == 0) p_first = k; p_last = k; end
            if (o[2]) begin s_cnt++; if (s_first == 0) s_first = k; end
            if (o[3]) begin h_cnt++; if (h_first == 0) h_first = k; end
            if (o[4]) begin r_cnt++; if (r_first == 0) r_first = k; end
            if (o[3] && o[4]) both_cnt++;
            if (rst_at > 0 && k == rst_at) begin
                reset = 1'b1;
                #1;
                check("reset_clears_outputs", int'(o), 0);
            end
            if (rst_at > 0 && k == rst_at + 3) reset = 1'b0;
            @(negedge clk);
        end
        press = 1'b0;
    endtask

    task automatic short_press_checks(input string pfx);
        check({pfx, "_press_cnt"}, p_cnt, 1);
        check({pfx, "_press_edge"}, p_first, 7);
        check({pfx, "_lvl_e6"}, int'(lvl_at[6]), 0);
        check({pfx, "_lvl_e7"}, int'(lvl_at[7]), 1);
        check({pfx, "_lvl_e18"}, int'(lvl_at[18]), 1);
        check({pfx, "_lvl_e19"}, int'(lvl_at[19]), 0);
        check({pfx, "_rel_cnt"}, r_cnt, 1);
        check({pfx, "_rel_edge"}, r_first, 19);
        check({pfx, "_short_cnt"}, s_cnt, 1);
        check({pfx, "_short_edge"}, s_first, 19);
        check({pfx, "_hold_cnt"}, h_cnt, 0);
        check({pfx, "_hact_cycles"}, hact_cnt, 0);
    endtask

    initial begin
        // Clean short press on the active-low pad
        sel = 1'b0;
        do_reset("rst_state_lo");
        run(30, 1, 12, 0, 0, 0, 1'b0);
        short_press_checks("short");

        // Bounce rejection
        do_reset("rst_state_b");
        run(30, 0, 0, 0, 0, 0, 1'b1);
        check("bounce_press_cnt", p_cnt, 0);
        check("bounce_rel_cnt", r_cnt, 0);
        check("bounce_short_cnt", s_cnt, 0);
        check("bounce_hold_cnt", h_cnt, 0);
        check("bounce_lvl_cycles", lvl_cnt, 0);

        // Long hold
        do_reset("rst_state_l");
        run(60, 1, 40, 0, 0, 0, 1'b0);
        check("long_press_edge", p_first, 7);
        check("long_hold_cnt", h_cnt, 1);
        check("long_hold_edge", h_first, 27);
        check("long_hact_e26", int'(hact_at[26]), 0);
        check("long_hact_e27", int'(hact_at[27]), 1);
        check("long_hact_e46", int'(hact_at[46]), 1);
        check("long_hact_e47", int'(hact_at[47]), 0);
        check("long_hact_cycles", hact_cnt, 20);
        check("long_rel_edge", r_first, 47);
        check("long_short_cnt", s_cnt, 0);
        check("long_excl", both_cnt, 0);

        // Release glitch while the hold count is running
        do_reset("rst_state_g");
        run(60, 1, 40, 15, 2, 0, 1'b0);
        check("glitch_press_cnt", p_cnt, 1);
        check("glitch_hold_edge", h_first, 30);
        check("glitch_hold_cnt", h_cnt, 1);
        check("glitch_rel_cnt", r_cnt, 1);
        check("glitch_rel_edge", r_first, 47);
        check("glitch_short_cnt", s_cnt, 0);

        // Reset mid-hold with the button still down
        do_reset("rst_state_r");
        run(70, 1, 55, 0, 0, 19, 1'b0);
        check("rmid_lvl_e19", int'(lvl_at[19]), 1);
        check("rmid_press_cnt", p_cnt, 2);
        check("rmid_press_first", p_first, 7);
        check("rmid_press_last", p_last, 29);
        check("rmid_hold_cnt", h_cnt, 1);
        check("rmid_hold_edge", h_first, 49);
        check("rmid_rel_edge", r_first, 62);
        check("rmid_short_cnt", s_cnt, 0);

        // Active-high pad: same timing as the clean short press
        sel = 1'b1;
        do_reset("rst_state_hi");
        run(30, 1, 12, 0, 0, 0, 1'b0);
        short_press_checks("pol");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
